// File: rtl/branch_unit_bht.sv
// ---------------------------------------------------------------------------
// branch_unit_bht
//
// Branch resolution plus a direct-mapped bimodal branch history table.
//
//   Fetch side   : lk_valid/lk_pc look up a 2-bit saturating counter; the
//                  prediction (counter MSB) appears one cycle later on
//                  pred_valid/pred_taken. pred_taken holds between lookups.
//   Execute side : ex_* resolves one of the six RV32I branch conditions.
//                  One cycle later res_valid/res_taken/res_mispredict/
//                  res_illegal report the outcome. Legal branches train the
//                  counter at ex_pc on the same edge that registers the result.
//   Statistics   : mispred_cnt counts reported mispredicts, saturating.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   lk_valid, lk_pc                 lookup request
//   pred_valid, pred_taken          prediction response
//   ex_valid, ex_pc, ex_funct3,
//   ex_rs1, ex_rs2, ex_pred_taken   branch in execute
//   res_valid, res_taken,
//   res_mispredict, res_illegal     registered resolution
//   mispred_cnt                     saturating mispredict count
// ---------------------------------------------------------------------------
module branch_unit_bht #(
  parameter int         XLEN     = 32,
  parameter int         IDX_BITS = 6,
  parameter logic [1:0] INIT_CNT = 2'b01,
  parameter int         CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lk_valid,
  input  logic [XLEN-1:0]  lk_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [2:0]       ex_funct3,
  input  logic [XLEN-1:0]  ex_rs1,
  input  logic [XLEN-1:0]  ex_rs2,
  input  logic             ex_pred_taken,
  output logic             res_valid,
  output logic             res_taken,
  output logic             res_mispredict,
  output logic             res_illegal,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [IDX_BITS-1:0] lk_idx;
  logic [IDX_BITS-1:0] ex_idx;

  // The word-aligned PC bits above the index and the byte offset do not
  // take part in indexing.
  logic unused_pc_bits;

  assign lk_idx = lk_pc[IDX_BITS+1:2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign unused_pc_bits = ^{lk_pc[XLEN-1:IDX_BITS+2], lk_pc[1:0],
                            ex_pc[XLEN-1:IDX_BITS+2], ex_pc[1:0]};

  // -------------------------------------------------------------------------
  // Branch condition
  // -------------------------------------------------------------------------
  logic cond_taken;
  logic cond_illegal;

  always_comb begin
    cond_taken   = 1'b0;
    cond_illegal = 1'b0;
    case (ex_funct3)
      3'b000:  cond_taken = (ex_rs1 == ex_rs2);
      3'b001:  cond_taken = (ex_rs1 != ex_rs2);
      3'b100:  cond_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
      3'b101:  cond_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
      3'b110:  cond_taken = (ex_rs1 <  ex_rs2);
      3'b111:  cond_taken = (ex_rs1 >= ex_rs2);
      default: cond_illegal = 1'b1;
    endcase
  end

  logic upd_en;
  assign upd_en = ex_valid && !cond_illegal;

  // -------------------------------------------------------------------------
  // Counter table. Each entry is its own flop pair so the whole table can be
  // returned to INIT_CNT by reset. Lookups read table_q, i.e. the value before
  // any update landing on the same edge (read-old).
  // -------------------------------------------------------------------------
  logic [1:0] table_q [ENTRIES];
  logic [1:0] table_d [ENTRIES];

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      always_comb begin
        table_d[gi] = table_q[gi];
        if (upd_en && (ex_idx == IDX_BITS'(gi))) begin
          if (cond_taken) begin
            if (table_q[gi] != 2'b11) table_d[gi] = table_q[gi] + 2'b01;
          end else begin
            if (table_q[gi] != 2'b00) table_d[gi] = table_q[gi] - 2'b01;
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) table_q[gi] <= INIT_CNT;
        else        table_q[gi] <= table_d[gi];
      end
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Prediction and resolution registers
  // -------------------------------------------------------------------------
  logic             pred_valid_q, pred_valid_d;
  logic             pred_taken_q, pred_taken_d;
  logic             res_valid_q, res_valid_d;
  logic             res_taken_q, res_taken_d;
  logic             res_mispredict_q, res_mispredict_d;
  logic             res_illegal_q, res_illegal_d;
  logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    pred_valid_d     = lk_valid;
    pred_taken_d     = pred_taken_q;
    if (lk_valid) pred_taken_d = table_q[lk_idx][1];

    res_valid_d      = ex_valid;
    res_taken_d      = ex_valid && cond_taken;
    res_illegal_d    = ex_valid && cond_illegal;
    res_mispredict_d = upd_en && (cond_taken != ex_pred_taken);

    // The count follows the reported mispredict flag, so it advances on the
    // edge after res_mispredict is seen high.
    mispred_cnt_d = mispred_cnt_q;
    if (res_valid_q && res_mispredict_q && (mispred_cnt_q != {CNT_W{1'b1}}))
      mispred_cnt_d = mispred_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q     <= 1'b0;
      pred_taken_q     <= 1'b0;
      res_valid_q      <= 1'b0;
      res_taken_q      <= 1'b0;
      res_mispredict_q <= 1'b0;
      res_illegal_q    <= 1'b0;
      mispred_cnt_q    <= '0;
    end else begin
      pred_valid_q     <= pred_valid_d;
      pred_taken_q     <= pred_taken_d;
      res_valid_q      <= res_valid_d;
      res_taken_q      <= res_taken_d;
      res_mispredict_q <= res_mispredict_d;
      res_illegal_q    <= res_illegal_d;
      mispred_cnt_q    <= mispred_cnt_d;
    end
  end

  assign pred_valid     = pred_valid_q;
  assign pred_taken     = pred_taken_q;
  assign res_valid      = res_valid_q;
  assign res_taken      = res_taken_q;
  assign res_mispredict = res_mispredict_q;
  assign res_illegal    = res_illegal_q;
  assign mispred_cnt    = mispred_cnt_q;

endmodule
